// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    StLen,
    StData,
    StCsum,
    StDone,
    StError
  } state_e;

  // Byte count of the LEN and CSUM fields, and of one instruction word.
  localparam int unsigned FieldBytes = 4;

endpackage

// File: rtl/byte_packer.sv
// Little-endian 8-to-32 assembler; word_valid_o fires combinationally with the 4th byte.
module byte_packer
  import program_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  input  logic        valid_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam int unsigned CntW = $clog2(FieldBytes);
  localparam logic [CntW-1:0] LastCnt = CntW'(FieldBytes - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [23:0]     part_q, part_d;

  always_comb begin
    cnt_d        = cnt_q;
    part_d       = part_q;
    word_valid_o = valid_i && (cnt_q == LastCnt);
    word_o       = {byte_i, part_q};
    if (valid_i) begin
      // Counter wraps to zero after the last byte of a word.
      cnt_d  = cnt_q + 1'b1;
      part_d = {byte_i, part_q[23:8]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      cnt_q  <= '0;
      part_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      part_q <= part_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed program image into instruction memory.
// Optional trailing checksum is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [ADDR_W:0] MaxWords = {1'b1, {ADDR_W{1'b0}}};

  state_e state_q, state_d;

  logic              accept;
  logic [31:0]       pk_word;
  logic              pk_valid;
  logic              data_end;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   n_q, n_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0]       csum_q, csum_d;
`endif

  assign accept = rx_valid && rx_ready;

  byte_packer u_byte_packer (
    .clk_i        (CLOCK_50),
    .clear_i      (reset),
    .byte_i       (rx_data),
    .valid_i      (accept),
    .word_o       (pk_word),
    .word_valid_o (pk_valid)
  );

  // Leave DATA only once the final write strobe is on the bus.
  assign data_end = (state_q == StData) && we_q && (idx_q == n_q);

  always_ff @(posedge CLOCK_50) begin
    if (reset) state_q <= StLen;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLen: begin
        if (pk_valid) begin
          if (pk_word > 32'(MaxWords)) begin
            state_d = StError;
          end else if (pk_word == 32'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (data_end) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = StCsum;
`else
          state_d = StDone;
`endif
        end
      end
      StCsum: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (pk_valid) state_d = (pk_word == csum_q) ? StDone : StError;
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    rx_ready   = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    core_reset = (state_q != StDone);
    load_done  = (state_q == StDone);
    load_error = (state_q == StError);
  end

  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    n_d     = n_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (state_q == StLen && pk_valid) begin
      n_d = pk_word[ADDR_W:0];
    end
    if (state_q == StData && pk_valid && idx_q != n_q) begin
      we_d    = 1'b1;
      addr_d  = idx_q[ADDR_W-1:0];
      wdata_d = pk_word;
      idx_d   = idx_q + 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_d  = csum_q + pk_word;
`endif
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      n_q     <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomised bench for program_loader with a queue-based image model.
module tb_program_loader;

  localparam int unsigned AW = 8;
  localparam int unsigned MaxWords = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_reset;
  logic          load_done;
  logic          load_error;

  always #5 clk = ~clk;

  program_loader #(.ADDR_W(AW)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_error (load_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [7:0]     stim_q[$];
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] got_q[$];
  int             exp_status;  // 1 = done, 2 = error
  int             consumed;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic prev_we = 1'b0;
  int   wide = 0;
  int   last_we_cyc = -1;
  int   first_free_cyc = -1;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_q.push_back({imem_addr, imem_wdata});
      last_we_cyc = cyc;
      if (prev_we) wide++;
    end
    prev_we = (imem_we === 1'b1);
    if (core_reset === 1'b0 && first_free_cyc < 0) first_free_cyc = cyc;
  end

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) stim_q.push_back(8'(w >> (8 * i)));
  endtask

  function automatic logic [31:0] stim_word(input int pos);
    return {stim_q[pos+3], stim_q[pos+2], stim_q[pos+1], stim_q[pos]};
  endfunction

  // Reference: parse the image from the byte queue with plain arithmetic.
  task automatic build_expect();
    logic [31:0] n, sum, w;
    int pos;
    exp_q.delete();
    n = stim_word(0);
    pos = 4;
    if (n > MaxWords) begin
      exp_status = 2;
      consumed = 4;
      return;
    end
    sum = 0;
    for (int k = 0; k < int'(n); k++) begin
      w = stim_word(pos);
      exp_q.push_back({AW'(k), w});
      sum += w;
      pos += 4;
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    exp_status = (stim_word(pos) == sum) ? 1 : 2;
    pos += 4;
`else
    exp_status = 1;
`endif
    consumed = pos;
  endtask

  task automatic make_random_image(input int n, input bit good_csum);
    logic [31:0] sum, w;
    stim_q.delete();
    push_word(32'(n));
    sum = 0;
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      push_word(w);
      sum += w;
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    push_word(good_csum ? sum : sum ^ (32'd1 << $urandom_range(0, 31)));
`else
    if (good_csum) w = sum;
`endif
  endtask

  task automatic make_directed(input logic [31:0] trailer);
    stim_q.delete();
    push_word(32'd2);
    push_word(32'h0050_0013);
    push_word(32'h00A0_0093);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    push_word(trailer);
`else
    if (trailer == 0) stim_q.push_back(8'h00);  // stray byte past the image is never sent
`endif
  endtask

  task automatic check_idle_state(input string name);
    check_eq({name, ".rx_ready"}, rx_ready, 1);
    check_eq({name, ".core_reset"}, core_reset, 1);
    check_eq({name, ".load_done"}, load_done, 0);
    check_eq({name, ".load_error"}, load_error, 0);
    check_eq({name, ".imem_we"}, imem_we, 0);
    check_eq({name, ".imem_addr"}, imem_addr, 0);
    check_eq({name, ".imem_wdata"}, imem_wdata, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    got_q.delete();
    wide = 0;
    last_we_cyc = -1;
    first_free_cyc = -1;
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
  task automatic send_bytes(input int count, input int mode);
    int gap;
    for (int i = 0; i < count; i++) begin
      gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 3));
      repeat (gap) begin
        rx_valid = 1'b0;
        rx_data = 8'($urandom);
        @(posedge clk);
        #1;
      end
      rx_valid = 1'b1;
      rx_data = stim_q[i];
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_image(input string name, input int mode, input bit with_reset);
    int t;
    if (with_reset) do_reset();
    else begin
      got_q.delete();
      wide = 0;
      last_we_cyc = -1;
      first_free_cyc = -1;
    end
    build_expect();
    send_bytes(consumed, mode);
    t = 0;
    while (!(load_done || load_error) && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    @(negedge clk);
    #1;
    check_eq({name, ".timeout"}, t < 20, 1);
    check_eq({name, ".load_done"}, load_done, exp_status == 1);
    check_eq({name, ".load_error"}, load_error, exp_status == 2);
    check_eq({name, ".core_reset"}, core_reset, exp_status != 1);
    check_eq({name, ".rx_ready"}, rx_ready, 0);
    check_eq({name, ".nwrites"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check_eq($sformatf("%s.write%0d", name, i), got_q[i], exp_q[i]);
    end
    check_eq({name, ".pulse_width"}, wide, 0);
    check_eq({name, ".we_idle"}, imem_we, 0);
    if (exp_q.size() > 0) begin
      check_eq({name, ".hold"}, {imem_addr, imem_wdata}, exp_q[exp_q.size()-1]);
      if (exp_status == 1) check_eq({name, ".order"}, first_free_cyc > last_we_cyc, 1);
    end
  endtask

  initial begin
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;

    do_reset();
    check_idle_state("reset");

    make_directed(32'h00F0_00A6);
    run_image("directed", 0, 1'b1);
    if (got_q.size() == 2) begin
      check_eq("directed.addr0", got_q[0], {8'h00, 32'h0050_0013});
      check_eq("directed.addr1", got_q[1], {8'h01, 32'h00A0_0093});
    end

    run_image("alternate", 1, 1'b1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    make_directed(32'h0000_0000);
    run_image("bad_csum", 0, 1'b1);
`endif

    stim_q.delete();
    push_word(32'h0000_0101);
    run_image("too_long", 0, 1'b1);

    stim_q.delete();
    push_word(32'h0000_0000);
    push_word(32'h0000_0000);
    run_image("empty", 2, 1'b1);

    make_random_image(MaxWords, 1'b1);
    run_image("full", 2, 1'b1);

    // Reset after two bytes of word 1.
    do_reset();
    make_directed(32'h00F0_00A6);
    send_bytes(10, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("midreset.writes_before", got_q.size(), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle_state("midreset");
    repeat (4) @(posedge clk);
    #1;
    check_eq("midreset.no_word1", got_q.size(), 1);
    run_image("resend", 0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      make_random_image(int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)));
      run_image($sformatf("rand%0d", r), 2, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
